// File: rtl/prt_scaler_vbs_ratio_if.sv
`default_nettype none
// ============================================================================
// Module   : prt_scaler_vbs_ratio_if
// Purpose  : Bundle of the control, output-timing, source-write and
//            scaled-output signals of the vertical bilinear scaler.
// Ports    : slave  - scaler side (timing/source/control in, data/status out)
//            master - driver side (mirror of slave)
// Revision : 1.0 - initial release
// ============================================================================
interface prt_scaler_vbs_ratio_if #(
    parameter int P_PPC  = 4,
    parameter int P_BPC  = 8,
    parameter int P_FRAC = 8
);
    logic                     CKE_IN;
    logic                     CTL_RUN_IN;
    logic [P_FRAC:0]          CTL_STEP_IN;
    logic                     VS_IN;
    logic                     HS_IN;
    logic                     DE_IN;
    logic                     WR_IN;
    logic                     EOL_IN;
    logic [P_PPC*P_BPC-1:0]   DAT_IN;
    logic                     LRDY_OUT;
    logic [P_PPC*P_BPC-1:0]   DAT_OUT;
    logic                     WR_OUT;
    logic                     STA_UFL_OUT;
    logic                     STA_OFL_OUT;

    modport slave (
        input  CKE_IN, CTL_RUN_IN, CTL_STEP_IN, VS_IN, HS_IN, DE_IN,
               WR_IN, EOL_IN, DAT_IN,
        output LRDY_OUT, DAT_OUT, WR_OUT, STA_UFL_OUT, STA_OFL_OUT
    );

    modport master (
        output CKE_IN, CTL_RUN_IN, CTL_STEP_IN, VS_IN, HS_IN, DE_IN,
               WR_IN, EOL_IN, DAT_IN,
        input  LRDY_OUT, DAT_OUT, WR_OUT, STA_UFL_OUT, STA_OFL_OUT
    );
endinterface
`default_nettype wire

// File: rtl/prt_scaler_vbs_ratio.sv
`default_nettype none
// ============================================================================
// Module   : prt_scaler_vbs_ratio
// Purpose  : Vertical bilinear scaler with programmable Q1.P_FRAC step.
//            Source lines fill a 3-entry line-buffer ring; output lines are
//            paced by VS/HS/DE and blended from the top/bottom ring pair
//            with a fractional phase accumulator.
// Ports    : CLK_IN  - clock
//            RST_IN  - asynchronous reset, active low
//            bus     - prt_scaler_vbs_ratio_if.slave (control, timing,
//                      source write, scaled output, sticky status)
// Revision : 1.0 - initial release
// ============================================================================
module prt_scaler_vbs_ratio #(
    parameter string P_VENDOR    = "none",
    parameter int    P_PPC       = 4,
    parameter int    P_BPC       = 8,
    parameter int    P_LINE_WRDS = 1024,
    parameter int    P_FRAC      = 8
) (
    input  wire logic              CLK_IN,
    input  wire logic              RST_IN,
    prt_scaler_vbs_ratio_if.slave  bus
);
    localparam int c_dw = P_PPC * P_BPC;
    localparam int c_aw = (P_LINE_WRDS > 1) ? $clog2(P_LINE_WRDS) : 1;
    localparam int c_pw = P_BPC + P_FRAC + 1;
    localparam logic [P_FRAC:0] c_one  = {1'b1, {P_FRAC{1'b0}}};
    localparam logic [c_pw-1:0] c_half = c_pw'(2 ** (P_FRAC - 1));

    typedef enum logic [1:0] {
        sm_idle = 2'd0,
        sm_act  = 2'd1,
        sm_adv  = 2'd2
    } state_t;

    // Ring index increment modulo 3 (b is 0..2).
    function automatic logic [1:0] f_add3(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t          r_state;
    logic            r_vs_d, r_hs_d, r_de_d;
    logic [P_FRAC:0] r_step;
    logic [P_FRAC-1:0] r_phase;
    logic [1:0]      r_fill, r_wb, r_tb;
    logic [c_aw-1:0] r_wadr, r_radr;
    logic            r_lrdy, r_ufl, r_ofl;

    logic            w_vs_rise, w_hs_rise, w_de_rise;
    logic            w_wr, w_full, w_wr_ok, w_eol_ok, w_rd_en, w_adv;
    logic [P_FRAC:0] w_step_eff;
    logic [P_FRAC+1:0] w_acc;
    logic [1:0]      w_n, w_avail, w_ret, w_fill_nxt;

    assign w_vs_rise  = bus.VS_IN & ~r_vs_d;
    assign w_hs_rise  = bus.HS_IN & ~r_hs_d;
    assign w_de_rise  = bus.DE_IN & ~r_de_d;

    assign w_wr       = bus.CKE_IN & bus.WR_IN & bus.CTL_RUN_IN;
    assign w_full     = (r_fill == 2'd3);
    assign w_wr_ok    = w_wr & ~w_full;
    assign w_eol_ok   = w_wr_ok & bus.EOL_IN;
    assign w_rd_en    = bus.DE_IN & bus.CTL_RUN_IN;

    // A zero step would freeze the phase; treat it as one LSB.
    assign w_step_eff = (r_step == '0) ? {{P_FRAC{1'b0}}, 1'b1} : r_step;
    assign w_acc      = {2'b00, r_phase} + {1'b0, w_step_eff};
    assign w_n        = w_acc[P_FRAC+1:P_FRAC];

    // Never retire the last buffered line: it stays as the repeat source.
    assign w_avail    = (r_fill == 2'd0) ? 2'd0 : r_fill - 2'd1;
    assign w_adv      = (r_state == sm_adv) & ~w_vs_rise;
    assign w_ret      = w_adv ? ((w_n < w_avail) ? w_n : w_avail) : 2'd0;
    // Write-side increment and read-side retire combine in one update.
    assign w_fill_nxt = r_fill + {1'b0, w_eol_ok} - w_ret;

    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            r_state <= sm_idle;
            r_vs_d  <= 1'b0;
            r_hs_d  <= 1'b0;
            r_de_d  <= 1'b0;
            r_step  <= '0;
            r_phase <= '0;
            r_fill  <= 2'd0;
            r_wb    <= 2'd0;
            r_tb    <= 2'd0;
            r_wadr  <= '0;
            r_radr  <= '0;
            r_lrdy  <= 1'b0;
            r_ufl   <= 1'b0;
            r_ofl   <= 1'b0;
        end else begin
            r_vs_d <= bus.VS_IN;
            r_hs_d <= bus.HS_IN;
            r_de_d <= bus.DE_IN;
            if (!bus.CTL_RUN_IN) begin
                // Stop flushes the ring; indices realigned so wb == tb + fill.
                r_state <= sm_idle;
                r_phase <= '0;
                r_fill  <= 2'd0;
                r_wb    <= 2'd0;
                r_tb    <= 2'd0;
                r_wadr  <= '0;
                r_radr  <= '0;
                r_lrdy  <= 1'b1;
            end else begin
                if (w_wr_ok) begin
                    if (bus.EOL_IN) begin
                        r_wadr <= '0;
                        r_wb   <= f_add3(r_wb, 2'd1);
                    end else begin
                        r_wadr <= r_wadr + 1'b1;
                    end
                end
                r_fill <= w_fill_nxt;
                r_lrdy <= (w_fill_nxt != 2'd3);

                // A new event in the VS cycle wins over the clear.
                if (w_wr & w_full)
                    r_ofl <= 1'b1;
                else if (w_vs_rise)
                    r_ofl <= 1'b0;
                if (w_rd_en && (r_fill == 2'd0))
                    r_ufl <= 1'b1;
                else if (w_vs_rise)
                    r_ufl <= 1'b0;

                if (w_vs_rise) begin
                    r_state <= sm_idle;
                    r_phase <= '0;
                    r_step  <= bus.CTL_STEP_IN;
                    r_radr  <= '0;
                end else begin
                    case (r_state)
                        sm_idle: begin
                            if (w_rd_en)   r_radr  <= r_radr + 1'b1;
                            if (w_de_rise) r_state <= sm_act;
                        end
                        sm_act: begin
                            if (w_rd_en)   r_radr  <= r_radr + 1'b1;
                            if (w_hs_rise) r_state <= sm_adv;
                        end
                        sm_adv: begin
                            r_radr  <= '0;
                            r_phase <= w_acc[P_FRAC-1:0];
                            r_tb    <= f_add3(r_tb, w_ret);
                            r_state <= sm_act;
                        end
                        default: r_state <= sm_idle;
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: every buffer is read at radr each cycle; the pair
    // selection happens after the registered read.
    // ------------------------------------------------------------------
    logic [2:0][c_dw-1:0] w_rd;

    for (genvar gi = 0; gi < 3; gi++) begin : g_buf
        logic [c_dw-1:0] r_q;
        assign w_rd[gi] = r_q;
        if (P_VENDOR == "lattice") begin : g_lattice
            (* syn_ramstyle = "block_ram" *) logic [c_dw-1:0] r_mem [P_LINE_WRDS];
            always_ff @(posedge CLK_IN) begin
                if (w_wr_ok && (r_wb == 2'(gi)))
                    r_mem[r_wadr] <= bus.DAT_IN;
                r_q <= r_mem[r_radr];
            end
        end else begin : g_generic
            (* ram_style = "block" *) logic [c_dw-1:0] r_mem [P_LINE_WRDS];
            always_ff @(posedge CLK_IN) begin
                if (w_wr_ok && (r_wb == 2'(gi)))
                    r_mem[r_wadr] <= bus.DAT_IN;
                r_q <= r_mem[r_radr];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: RAM read plus captured pair selection and weight.
    // ------------------------------------------------------------------
    logic              r_s1_v, r_s1_zero;
    logic [1:0]        r_s1_tsel, r_s1_bsel;
    logic [P_FRAC-1:0] r_s1_w;

    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            r_s1_v    <= 1'b0;
            r_s1_zero <= 1'b0;
            r_s1_tsel <= 2'd0;
            r_s1_bsel <= 2'd0;
            r_s1_w    <= '0;
        end else begin
            r_s1_v    <= w_rd_en;
            r_s1_zero <= (r_fill == 2'd0);
            r_s1_tsel <= r_tb;
            // Single buffered line: repeat it with zero weight.
            r_s1_bsel <= (r_fill <= 2'd1) ? r_tb : f_add3(r_tb, 2'd1);
            r_s1_w    <= (r_fill <= 2'd1) ? '0 : r_phase;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: weighted products; stage 3: round and register outputs.
    // ------------------------------------------------------------------
    logic [c_dw-1:0]             w_top, w_bot, w_res;
    logic [P_FRAC:0]             w_wt, w_wb;
    logic [P_PPC-1:0][c_pw-1:0]  w_sum, r_s2_sum;
    logic                        r_s2_v, r_s2_zero;
    logic [c_dw-1:0]             r_dat;
    logic                        r_wr;

    assign w_top = w_rd[r_s1_tsel];
    assign w_bot = w_rd[r_s1_bsel];
    assign w_wb  = {1'b0, r_s1_w};
    assign w_wt  = c_one - w_wb;

    for (genvar gl = 0; gl < P_PPC; gl++) begin : g_lane
        logic [c_pw-1:0] w_t, w_b;
        assign w_t        = c_pw'(w_top[gl*P_BPC +: P_BPC]);
        assign w_b        = c_pw'(w_bot[gl*P_BPC +: P_BPC]);
        assign w_sum[gl]  = w_t * c_pw'(w_wt) + w_b * c_pw'(w_wb);
        // Weights sum to 2^F, so the rounded quotient fits P_BPC bits.
        assign w_res[gl*P_BPC +: P_BPC] = P_BPC'((r_s2_sum[gl] + c_half) >> P_FRAC);
    end

    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            r_s2_v    <= 1'b0;
            r_s2_zero <= 1'b0;
            r_s2_sum  <= '0;
            r_wr      <= 1'b0;
            r_dat     <= '0;
        end else begin
            r_s2_v    <= r_s1_v;
            r_s2_zero <= r_s1_zero;
            r_s2_sum  <= w_sum;
            r_wr      <= r_s2_v;
            r_dat     <= r_s2_zero ? '0 : w_res;
        end
    end

    assign bus.DAT_OUT     = r_dat;
    assign bus.WR_OUT      = r_wr;
    assign bus.LRDY_OUT    = r_lrdy;
    assign bus.STA_UFL_OUT = r_ufl;
    assign bus.STA_OFL_OUT = r_ofl;

endmodule
`default_nettype wire

// File: tb/tb_prt_scaler_vbs_ratio.sv
`default_nettype none
// ============================================================================
// Module   : tb_prt_scaler_vbs_ratio
// Purpose  : Directed self-checking bench for prt_scaler_vbs_ratio.
//            Expected pixel values are hand-computed bilinear results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prt_scaler_vbs_ratio;
    localparam int P_PPC       = 2;
    localparam int P_BPC       = 8;
    localparam int P_FRAC      = 8;
    localparam int P_LINE_WRDS = 8;
    localparam int c_len       = 4;   // words per source/output line

    logic CLK_IN = 1'b0;
    logic RST_IN = 1'b0;
    int   n_vec  = 0;
    int   n_err  = 0;

    always #5 CLK_IN = ~CLK_IN;

    prt_scaler_vbs_ratio_if #(.P_PPC(P_PPC), .P_BPC(P_BPC), .P_FRAC(P_FRAC)) bus ();

    prt_scaler_vbs_ratio #(
        .P_VENDOR    ("none"),
        .P_PPC       (P_PPC),
        .P_BPC       (P_BPC),
        .P_LINE_WRDS (P_LINE_WRDS),
        .P_FRAC      (P_FRAC)
    ) dut (
        .CLK_IN (CLK_IN),
        .RST_IN (RST_IN),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_IN);
        #1;
    endtask

    task automatic vs_pulse();
        bus.VS_IN = 1'b1; tick();
        bus.VS_IN = 1'b0; tick();
    endtask

    task automatic hs_pulse();
        bus.HS_IN = 1'b1; tick();
        bus.HS_IN = 1'b0; tick(); tick();
    endtask

    task automatic flush();
        bus.CTL_RUN_IN = 1'b0; tick();
        bus.CTL_RUN_IN = 1'b1; tick();
    endtask

    task automatic write_line(input logic [7:0] lo, input logic [7:0] hi);
        for (int w = 0; w < c_len; w++) begin
            bus.WR_IN  = 1'b1;
            bus.EOL_IN = (w == c_len - 1);
            bus.DAT_IN = {hi, lo};
            tick();
        end
        bus.WR_IN  = 1'b0;
        bus.EOL_IN = 1'b0;
    endtask

    // Drives one DE line and checks WR_OUT shape (3-cycle delay) and data.
    task automatic out_line(input string tag, input logic [7:0] elo, input logic [7:0] ehi);
        for (int c = 0; c < c_len + 4; c++) begin
            bus.DE_IN = (c < c_len);
            chk($sformatf("%s.wr%0d", tag, c), 32'(bus.WR_OUT),
                32'((c >= 3) && (c < c_len + 3)));
            if ((c >= 3) && (c < c_len + 3))
                chk($sformatf("%s.dat%0d", tag, c), 32'(bus.DAT_OUT), {16'h0, ehi, elo});
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.CKE_IN      = 1'b1;
        bus.CTL_RUN_IN  = 1'b1;
        bus.CTL_STEP_IN = '0;
        bus.VS_IN       = 1'b0;
        bus.HS_IN       = 1'b0;
        bus.DE_IN       = 1'b0;
        bus.WR_IN       = 1'b0;
        bus.EOL_IN      = 1'b0;
        bus.DAT_IN      = '0;

        // Reset state
        tick(); tick(); tick();
        chk("rst.wr",   32'(bus.WR_OUT),      32'h0);
        chk("rst.dat",  32'(bus.DAT_OUT),     32'h0);
        chk("rst.lrdy", 32'(bus.LRDY_OUT),    32'h0);
        chk("rst.ufl",  32'(bus.STA_UFL_OUT), 32'h0);
        chk("rst.ofl",  32'(bus.STA_OFL_OUT), 32'h0);
        RST_IN = 1'b1;
        tick(); tick();
        chk("rel.lrdy", 32'(bus.LRDY_OUT), 32'h1);

        // 1: step 0.5, lines 10/20/30 -> 10,15,20,25,30,30
        bus.CTL_STEP_IN = 9'h080;
        vs_pulse();
        write_line(8'd10, 8'd10);
        write_line(8'd20, 8'd20);
        write_line(8'd30, 8'd30);
        chk("t1.lrdy", 32'(bus.LRDY_OUT), 32'h0);
        out_line("t1.l0", 8'd10, 8'd10); hs_pulse();
        out_line("t1.l1", 8'd15, 8'd15); hs_pulse();
        out_line("t1.l2", 8'd20, 8'd20); hs_pulse();
        out_line("t1.l3", 8'd25, 8'd25); hs_pulse();
        out_line("t1.l4", 8'd30, 8'd30); hs_pulse();
        out_line("t1.l5", 8'd30, 8'd30); hs_pulse();
        chk("t1.ufl", 32'(bus.STA_UFL_OUT), 32'h0);

        // 2: step 1.0, four source lines pass through unchanged
        flush();
        bus.CTL_STEP_IN = 9'h100;
        vs_pulse();
        write_line(8'd40,  8'd43);
        write_line(8'd77,  8'd80);
        write_line(8'd200, 8'd203);
        out_line("t2.l0", 8'd40, 8'd43); hs_pulse();
        chk("t2.lrdy", 32'(bus.LRDY_OUT), 32'h1);
        write_line(8'd123, 8'd126);
        out_line("t2.l1", 8'd77,  8'd80);  hs_pulse();
        out_line("t2.l2", 8'd200, 8'd203); hs_pulse();
        out_line("t2.l3", 8'd123, 8'd126); hs_pulse();

        // 3: step 0.25 between 0 and 255 (and inverse lane)
        flush();
        bus.CTL_STEP_IN = 9'h040;
        vs_pulse();
        write_line(8'd0,   8'd255);
        write_line(8'd255, 8'd0);
        write_line(8'd255, 8'd0);
        out_line("t3.l0", 8'd0,   8'd255); hs_pulse();
        out_line("t3.l1", 8'd64,  8'd191); hs_pulse();
        out_line("t3.l2", 8'd128, 8'd128); hs_pulse();
        out_line("t3.l3", 8'd191, 8'd64);  hs_pulse();
        out_line("t3.l4", 8'd255, 8'd0);   hs_pulse();

        // 4: overflow with no output activity
        flush();
        vs_pulse();
        write_line(8'd1, 8'd1);
        write_line(8'd2, 8'd2);
        chk("t4.lrdy2", 32'(bus.LRDY_OUT), 32'h1);
        write_line(8'd3, 8'd3);
        chk("t4.lrdy3", 32'(bus.LRDY_OUT),    32'h0);
        chk("t4.ofl0",  32'(bus.STA_OFL_OUT), 32'h0);
        write_line(8'd4, 8'd4);
        chk("t4.ofl1",  32'(bus.STA_OFL_OUT), 32'h1);
        chk("t4.lrdy4", 32'(bus.LRDY_OUT),    32'h0);
        vs_pulse();
        chk("t4.oflc",  32'(bus.STA_OFL_OUT), 32'h0);

        // 5: underrun on empty ring
        flush();
        vs_pulse();
        chk("t5.ufl0", 32'(bus.STA_UFL_OUT), 32'h0);
        out_line("t5.l0", 8'd0, 8'd0);
        chk("t5.ufl1", 32'(bus.STA_UFL_OUT), 32'h1);
        vs_pulse();
        chk("t5.uflc", 32'(bus.STA_UFL_OUT), 32'h0);

        // 6: reset mid-line, then a clean frame
        flush();
        bus.CTL_STEP_IN = 9'h100;
        vs_pulse();
        write_line(8'd50, 8'd50);
        write_line(8'd60, 8'd60);
        bus.DE_IN = 1'b1;
        tick(); tick(); tick(); tick();
        chk("t6.wr_pre", 32'(bus.WR_OUT), 32'h1);
        RST_IN = 1'b0;
        #1;
        chk("t6.wr",   32'(bus.WR_OUT),   32'h0);
        chk("t6.dat",  32'(bus.DAT_OUT),  32'h0);
        chk("t6.lrdy", 32'(bus.LRDY_OUT), 32'h0);
        bus.DE_IN = 1'b0;
        tick();
        RST_IN = 1'b1;
        tick(); tick();
        chk("t6.lrdy_rel", 32'(bus.LRDY_OUT), 32'h1);
        bus.CTL_STEP_IN = 9'h080;
        vs_pulse();
        write_line(8'd10, 8'd10);
        write_line(8'd20, 8'd20);
        out_line("t6.l0", 8'd10, 8'd10); hs_pulse();
        out_line("t6.l1", 8'd15, 8'd15); hs_pulse();
        out_line("t6.l2", 8'd20, 8'd20); hs_pulse();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
